game_sequencer: RTL and testbench

Top-level session controller for the dino game. It sequences `game_fsm` through idle, arm, play and game-over phases, and generates the `game_tick` pulse train that `game_fsm` and the obstacle logic consume. It also keeps the BCD score and ramps the tick rate up as the score grows. It sits between the debounced button inputs and `game_fsm`, and drives the score display path.

---
 rtl/game_pkg.sv | 34 +++
 rtl/tick_divider.sv | 47 ++++
 rtl/game_sequencer.sv | 158 +++++++++++++++
 tb/tb_game_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the dino game session controller.
// Holds the state encoding, the score width and the BCD increment helper.
// Pure package: no ports, no timing, no flow control.
package game_pkg;

  localparam int SCORE_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  // Adds one to a 4-digit BCD value; each digit wraps 9->0 and carries into
  // the next. 9999 wraps to 0000, so callers saturate before calling.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic               carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < SCORE_W / 4; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Purpose: programmable period divider producing the game tick pulse.
// Latency: tick is registered, high the cycle after the counter wraps.
// Backpressure: none; runs freely while en is high, holds while en is low.
//
// Ports: clk, rst_n (async active-low), clr (zero the count and load period),
//        en (count enable), period (cycles per tick), tick (1-cycle pulse).
module tick_divider #(
  parameter int unsigned W          = 20,
  parameter int unsigned RST_PERIOD = 833_333
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] r_cnt;
  // Period in force for the count in progress. It is sampled only on clear
  // and on wrap, so a period change lands at the start of the next count.
  logic [W-1:0] r_per;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_per <= W'(RST_PERIOD);
      tick  <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_per <= period;
      tick  <= 1'b0;
    end else if (en) begin
      if (r_cnt == r_per - W'(1)) begin
        r_cnt <= '0;
        r_per <= period;
        tick  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + W'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Purpose: dino game session controller (IDLE/ARM/PLAY/OVER), tick generation,
//          BCD scoring with speed ramp. Optional high score: GAME_HISCORE_EN.
// Latency: start edge -> ARM next cycle -> PLAY the cycle after; no backpressure.
//
// Ports: clk, rst_n (async active-low), start_btn (debounced level),
//        game_over_in (from game_fsm), fsm_rst (reset to game_fsm/obstacles),
//        game_tick (registered pulse), state (IDLE=0 ARM=1 PLAY=2 OVER=3),
//        score_bcd (4-digit BCD), hiscore_bcd (only with GAME_HISCORE_EN).
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_BASE = 833_333,
  parameter int unsigned TICK_MIN  = 416_666,
  parameter int unsigned TICK_STEP = 8_333,
  parameter int unsigned SCORE_DIV = 6,
  parameter int unsigned OVER_HOLD = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic               game_over_in,
  output logic               fsm_rst,
  output logic               game_tick,
  output logic [1:0]         state,
`ifdef GAME_HISCORE_EN
  output logic [SCORE_W-1:0] hiscore_bcd,
`endif
  output logic [SCORE_W-1:0] score_bcd
);

  localparam int unsigned DIV_W  = $clog2(TICK_BASE + 1);
  localparam int unsigned SUB_W  = $clog2(SCORE_DIV + 1);
  localparam int unsigned HOLD_W = $clog2(OVER_HOLD + 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_btn_prev;
  logic               w_start_edge;
  logic [HOLD_W-1:0]  r_hold;
  logic               w_hold_done;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_inc;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [SUB_W-1:0]   r_sub;
  logic [DIV_W-1:0]   r_period;
  logic [DIV_W-1:0]   w_div_period;
  logic               w_div_en;
  logic               w_score_tick;
  logic               w_point;
  logic               w_sat;
  logic               w_hundred;

  // Previous-value register resets low so a button held through reset
  // release registers as a start edge on the first cycle.
  assign w_start_edge = start_btn & ~r_btn_prev;
  assign w_hold_done  = (r_hold == HOLD_W'(OVER_HOLD - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_edge) w_state_nxt = ST_ARM;
      ST_ARM:  w_state_nxt = ST_PLAY;
      ST_PLAY: if (game_over_in) w_state_nxt = ST_OVER;
      ST_OVER: if (w_start_edge && w_hold_done) w_state_nxt = ST_ARM;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_btn_prev <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_btn_prev <= start_btn;
      if (r_state != ST_OVER) begin
        r_hold <= '0;
      end else if (!w_hold_done) begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  // Divider is frozen on the game-over sample cycle so the first OVER cycle
  // can never carry a tick; a tick already visible on that cycle still counts.
  assign w_div_en     = (r_state == ST_PLAY) && !game_over_in;
  // ARM loads the base period straight into the divider, since r_period is
  // only reset to base on the same edge.
  assign w_div_period = (r_state == ST_ARM) ? DIV_W'(TICK_BASE) : r_period;

  tick_divider #(
    .W          (DIV_W),
    .RST_PERIOD (TICK_BASE)
  ) u_tick_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (r_state == ST_ARM),
    .en     (w_div_en),
    .period (w_div_period),
    .tick   (game_tick)
  );

  assign w_score_tick = (r_state == ST_PLAY) && game_tick;
  assign w_point      = w_score_tick && (r_sub == SUB_W'(SCORE_DIV - 1));
  assign w_sat        = (r_score == 16'h9999);
  assign w_score_inc  = bcd_inc(r_score);
  assign w_score_nxt  = (w_point && !w_sat) ? w_score_inc : r_score;
  assign w_hundred    = w_point && !w_sat && (w_score_inc[7:0] == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score  <= '0;
      r_sub    <= '0;
      r_period <= DIV_W'(TICK_BASE);
    end else if (r_state == ST_ARM) begin
      r_score  <= '0;
      r_sub    <= '0;
      r_period <= DIV_W'(TICK_BASE);
    end else if (w_score_tick) begin
      r_score <= w_score_nxt;
      if (r_sub == SUB_W'(SCORE_DIV - 1)) begin
        r_sub <= '0;
      end else begin
        r_sub <= r_sub + SUB_W'(1);
      end
      // Speed up at every 100-point boundary, never below the floor.
      if (w_hundred) begin
        if (32'(r_period) >= TICK_MIN + TICK_STEP) begin
          r_period <= r_period - DIV_W'(TICK_STEP);
        end else begin
          r_period <= DIV_W'(TICK_MIN);
        end
      end
    end
  end

`ifdef GAME_HISCORE_EN
  logic [SCORE_W-1:0] r_hiscore;

  // Compares against the next score so a point earned on the game-over
  // sample cycle is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hiscore <= '0;
    end else if ((r_state == ST_PLAY) && game_over_in && (w_score_nxt > r_hiscore)) begin
      r_hiscore <= w_score_nxt;
    end
  end

  assign hiscore_bcd = r_hiscore;
`endif

  assign state     = r_state;
  assign score_bcd = r_score;
  assign fsm_rst   = (r_state == ST_IDLE) || (r_state == ST_ARM);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small periods.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Covers reset, start latency, tick spacing, scoring, ramp, game over, saturation.
module tb_game_sequencer;

  localparam int TB = 10;
  localparam int TM = 4;
  localparam int TS = 2;
  localparam int SD = 2;
  localparam int OH = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_btn;
  logic        game_over_in;
  logic        fsm_rst;
  logic        game_tick;
  logic [1:0]  state;
  logic [15:0] score_bcd;
`ifdef GAME_HISCORE_EN
  logic [15:0] hiscore_bcd;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_BASE (TB),
    .TICK_MIN  (TM),
    .TICK_STEP (TS),
    .SCORE_DIV (SD),
    .OVER_HOLD (OH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_btn    (start_btn),
    .game_over_in (game_over_in),
    .fsm_rst      (fsm_rst),
    .game_tick    (game_tick),
    .state        (state),
`ifdef GAME_HISCORE_EN
    .hiscore_bcd  (hiscore_bcd),
`endif
    .score_bcd    (score_bcd)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s (tick %0d): observed=%0h expected=%0h", tag, k, obs, want);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Score visible on the cycle of tick kk reflects the kk-1 earlier ticks.
  function automatic logic [15:0] exp_score(input int kk);
    int s;
    s = (kk - 1) / SD;
    if (s > 9999) s = 9999;
    return to_bcd(s);
  endfunction

  // The count ending in tick kk started at tick kk-1 and uses the period
  // sampled one cycle earlier, i.e. after the score from kk-2 ticks.
  function automatic int exp_gap(input int kk);
    int s;
    int p;
    if (kk < 2) return TB;
    s = (kk - 2) / SD;
    if (s > 9999) s = 9999;
    p = TB - TS * (s / 100);
    if (p < TM) p = TM;
    return p;
  endfunction

  task automatic wait_tick(output int gap);
    gap = 0;
    do begin
      cyc();
      gap++;
    end while (game_tick !== 1'b1 && gap < 40);
    if (game_tick !== 1'b1) begin
      n_chk++;
      n_fail++;
      $error("FAIL tick_timeout (tick %0d): observed=no tick expected=tick within 40 cycles", k + 1);
    end
  endtask

  task automatic run_ticks(input int last);
    int gap;
    while (k < last) begin
      k++;
      wait_tick(gap);
      chk("tick_gap", 32'(gap), 32'(exp_gap(k)));
      chk("tick_score", {16'h0, score_bcd}, {16'h0, exp_score(k)});
    end
  endtask

  initial begin
    int nt;
    rst_n        = 1'b0;
    start_btn    = 1'b0;
    game_over_in = 1'b0;
    repeat (3) cyc();
    chk("rst_state", 32'(state), 32'(0));
    chk("rst_fsm_rst", 32'(fsm_rst), 32'(1));
    chk("rst_tick", 32'(game_tick), 32'(0));
    chk("rst_score", 32'(score_bcd), 32'(0));
`ifdef GAME_HISCORE_EN
    chk("rst_hiscore", 32'(hiscore_bcd), 32'(0));
`endif
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("idle_hold", 32'(state), 32'(0));

    // Game 1: start latency, base spacing, coincident tick and game over.
    start_btn = 1'b1;
    cyc();
    chk("start_arm", 32'(state), 32'(1));
    chk("arm_fsm_rst", 32'(fsm_rst), 32'(1));
    start_btn = 1'b0;
    cyc();
    chk("start_play", 32'(state), 32'(2));
    chk("play_fsm_rst", 32'(fsm_rst), 32'(0));
    chk("play_score0", 32'(score_bcd), 32'(0));
    run_ticks(14);
    game_over_in = 1'b1;
    cyc();
    game_over_in = 1'b0;
    chk("over_state", 32'(state), 32'(3));
    chk("over_no_tick", 32'(game_tick), 32'(0));
    chk("over_fsm_rst", 32'(fsm_rst), 32'(0));
    chk("over_score_kept", 32'(score_bcd), 32'h0007);
`ifdef GAME_HISCORE_EN
    chk("hiscore_g1", 32'(hiscore_bcd), 32'h0007);
`endif
    cyc();
    cyc();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    chk("early_start_ignored", 32'(state), 32'(3));
    nt = 0;
    repeat (50) begin
      cyc();
      if (game_tick === 1'b1) nt++;
    end
    chk("over_ticks", 32'(nt), 32'(0));
    chk("over_score_frozen", 32'(score_bcd), 32'h0007);
    chk("over_state_held", 32'(state), 32'(3));
    start_btn = 1'b1;
    cyc();
    chk("restart1_arm", 32'(state), 32'(1));
    start_btn = 1'b0;
    cyc();
    chk("restart1_play", 32'(state), 32'(2));
    chk("restart1_score", 32'(score_bcd), 32'(0));
`ifdef GAME_HISCORE_EN
    chk("hiscore_after_arm", 32'(hiscore_bcd), 32'h0007);
`endif

    // Game 2: lower score, restart exactly at OVER cycle 6.
    k = 0;
    run_ticks(6);
    cyc();
    game_over_in = 1'b1;
    cyc();
    game_over_in = 1'b0;
    chk("g2_over", 32'(state), 32'(3));
    chk("g2_score", 32'(score_bcd), 32'h0003);
`ifdef GAME_HISCORE_EN
    chk("hiscore_g2", 32'(hiscore_bcd), 32'h0007);
`endif
    repeat (6) cyc();
    start_btn = 1'b1;
    cyc();
    chk("restart2_arm", 32'(state), 32'(1));
    start_btn = 1'b0;
    cyc();
    chk("restart2_play", 32'(state), 32'(2));
    chk("restart2_score", 32'(score_bcd), 32'(0));

    // Game 3: ramp to the floor and saturate at 9999.
    k = 0;
    run_ticks(20000);
    chk("sat_state", 32'(state), 32'(2));
    chk("sat_score", 32'(score_bcd), 32'h9999);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'(0));
    chk("mid_rst_tick", 32'(game_tick), 32'(0));
    chk("mid_rst_fsm_rst", 32'(fsm_rst), 32'(1));
    chk("mid_rst_score", 32'(score_bcd), 32'(0));
`ifdef GAME_HISCORE_EN
    chk("mid_rst_hiscore", 32'(hiscore_bcd), 32'(0));
`endif
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", 32'(state), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
